// File: rtl/bpred_unit_pkg.sv
// Shared types and constants for the branch-prediction unit: table geometry,
// counter and BTAC entry types, FSM states and the branch opcodes used by decode.
package bpred_unit_pkg;

  localparam int IDX_W = 8;
  localparam int GHR_W = 2;
  localparam int N_ENT = 2 ** IDX_W;
  localparam int N_CNT = 2 ** GHR_W;
  localparam int TAG_W = 32 - IDX_W;

  typedef logic [1:0] cnt_t;
  localparam cnt_t CNT_INIT = 2'b01;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
  } btac_t;

  localparam btac_t BTAC_CLR = '{tag: {TAG_W{1'b0}}, target: 32'd0};

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Decode helper shared with the core: does this opcode redirect control flow?
  function automatic logic is_branch_op(input logic [6:0] opcode);
    case (opcode)
      OP_JAL, OP_JALR, OP_BRANCH: is_branch_op = 1'b1;
      default:                    is_branch_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bpred_unit_sat_counter2.sv
// Next value of a 2-bit saturating branch counter, moved one step toward the
// resolved outcome and clamped at 2'b00 / 2'b11.
module sat_counter2
  import bpred_unit_pkg::*;
(
  input  cnt_t cur,
  input  logic taken,
  output cnt_t nxt
);

  // One step toward the outcome, holding at either end of the range.
  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != 2'b11) begin
        nxt = cur + 2'b01;
      end else begin
        nxt = cur;
      end
    end else begin
      if (cur != 2'b00) begin
        nxt = cur - 2'b01;
      end else begin
        nxt = cur;
      end
    end
  end

endmodule

// File: rtl/bpred_unit.sv
// Branch-prediction responder: global-history-indexed BHT of 2-bit counters,
// tagged BTAC and resolved-branch statistics, with a walking table initialiser.
module bpred_unit
  import bpred_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  output logic             ready,
  input  logic             lk_valid,
  input  logic [31:0]      lk_pc,
  input  logic             lk_is_branch,
  output logic             pr_valid,
  output logic             pr_taken,
  output logic [31:0]      pr_target,
  output logic [GHR_W-1:0] pr_ghr,
  input  logic             up_valid,
  input  logic [31:0]      up_pc,
  input  logic [GHR_W-1:0] up_ghr,
  input  logic             up_taken,
  input  logic [31:0]      up_target,
  input  logic             up_mispred,
  output logic [31:0]      st_total,
  output logic [31:0]      st_hit,
  output logic [31:0]      st_miss
);

  state_t           state_r;
  logic [IDX_W-1:0] idx_r;
  logic [GHR_W-1:0] ghr_r;

  cnt_t  bht_r  [N_ENT][N_CNT];
  btac_t btac_r [N_ENT];

  logic [IDX_W-1:0] lk_ix_s;
  logic [TAG_W-1:0] lk_tag_s;
  btac_t            lk_entry_s;
  logic             lk_hit_s;
  logic             lk_taken_s;
  logic [31:0]      lk_target_s;

  logic [IDX_W-1:0] up_ix_s;
  logic [TAG_W-1:0] up_tag_s;
  cnt_t             up_cnt_s;
  cnt_t             up_cnt_nxt_s;

  logic             run_s;
  logic             tbl_init_s;
  logic             tbl_upd_s;

  // Lookup reads the tables as they stood before this cycle's update.
  always_comb begin
    lk_ix_s     = lk_pc[IDX_W-1:0];
    lk_tag_s    = lk_pc[31:IDX_W];
    lk_entry_s  = btac_r[lk_ix_s];
    lk_hit_s    = (lk_entry_s.tag == lk_tag_s);
    lk_taken_s  = lk_is_branch & bht_r[lk_ix_s][ghr_r][1] & lk_hit_s;
    if (lk_taken_s) begin
      lk_target_s = lk_entry_s.target;
    end else begin
      lk_target_s = lk_pc + 32'd1;
    end
  end

  // Update-side addressing and table write enables.
  always_comb begin
    up_ix_s    = up_pc[IDX_W-1:0];
    up_tag_s   = up_pc[31:IDX_W];
    up_cnt_s   = bht_r[up_ix_s][up_ghr];
    run_s      = (state_r == RUN);
    tbl_init_s = !rstn && (state_r == INIT);
    tbl_upd_s  = !rstn && run_s && up_valid;
  end

  sat_counter2 u_sat (
    .cur   (up_cnt_s),
    .taken (up_taken),
    .nxt   (up_cnt_nxt_s)
  );

  // FSM, history register, prediction response and statistics.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_r   <= INIT;
      idx_r     <= {IDX_W{1'b0}};
      ghr_r     <= {GHR_W{1'b0}};
      ready     <= 1'b0;
      pr_valid  <= 1'b0;
      pr_taken  <= 1'b0;
      pr_target <= 32'd0;
      pr_ghr    <= {GHR_W{1'b0}};
      st_total  <= 32'd0;
      st_hit    <= 32'd0;
      st_miss   <= 32'd0;
    end else begin
      case (state_r)
        INIT: begin
          pr_valid <= 1'b0;
          idx_r    <= idx_r + IDX_W'(1);
          if (idx_r == {IDX_W{1'b1}}) begin
            state_r <= RUN;
            ready   <= 1'b1;
          end
        end
        RUN: begin
          pr_valid <= lk_valid;
          if (lk_valid) begin
            pr_taken  <= lk_taken_s;
            pr_target <= lk_target_s;
            pr_ghr    <= ghr_r;
          end
          if (up_valid) begin
            ghr_r    <= {ghr_r[GHR_W-2:0], up_taken};
            st_total <= st_total + 32'd1;
            if (up_mispred) begin
              st_miss <= st_miss + 32'd1;
            end else begin
              st_hit  <= st_hit + 32'd1;
            end
          end
        end
        default: begin
          state_r  <= INIT;
          idx_r    <= {IDX_W{1'b0}};
          ready    <= 1'b0;
          pr_valid <= 1'b0;
        end
      endcase
    end
  end

  // Table storage: no reset of its own, contents are defined by the INIT walk.
  always_ff @(posedge clk) begin
    if (tbl_init_s) begin
      for (int g = 0; g < N_CNT; g++) begin
        bht_r[idx_r][g] <= CNT_INIT;
      end
      btac_r[idx_r] <= BTAC_CLR;
    end else if (tbl_upd_s) begin
      bht_r[up_ix_s][up_ghr] <= up_cnt_nxt_s;
      if (up_taken) begin
        btac_r[up_ix_s] <= '{tag: up_tag_s, target: up_target};
      end
    end
  end

endmodule

// File: tb/tb_bpred_unit.sv
// Self-checking bench for bpred_unit: directed vector table, reset corner
// sequences and a randomized run against a behavioural predictor model.
module tb_bpred_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ready;
  logic        lk_valid;
  logic [31:0] lk_pc;
  logic        lk_is_branch;
  logic        pr_valid;
  logic        pr_taken;
  logic [31:0] pr_target;
  logic [1:0]  pr_ghr;
  logic        up_valid;
  logic [31:0] up_pc;
  logic [1:0]  up_ghr;
  logic        up_taken;
  logic [31:0] up_target;
  logic        up_mispred;
  logic [31:0] st_total;
  logic [31:0] st_hit;
  logic [31:0] st_miss;

  int errors = 0;
  int checks = 0;

  bpred_unit dut (
    .clk(clk), .rstn(rstn), .ready(ready),
    .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_is_branch(lk_is_branch),
    .pr_valid(pr_valid), .pr_taken(pr_taken), .pr_target(pr_target), .pr_ghr(pr_ghr),
    .up_valid(up_valid), .up_pc(up_pc), .up_ghr(up_ghr), .up_taken(up_taken),
    .up_target(up_target), .up_mispred(up_mispred),
    .st_total(st_total), .st_hit(st_hit), .st_miss(st_miss)
  );

  always #5 clk = ~clk;

  // Behavioural model: counters as integers 0..3, taken when counter >= 2.
  int          m_cnt [256][4];
  logic [23:0] m_tag [256];
  logic [31:0] m_tgt [256];
  int          m_ghr;
  logic [31:0] m_total, m_hit, m_miss;
  logic        m_valid, m_taken;
  logic [31:0] m_target;
  logic [1:0]  m_pghr;

  typedef struct {
    logic lv; logic [31:0] lpc; logic lbr;
    logic uv; logic [31:0] upc; logic [1:0] ug; logic ut; logic [31:0] utgt; logic um;
    logic ev; logic et; logic [31:0] etgt; logic [1:0] eg;
    logic [31:0] etot; logic [31:0] ehit; logic [31:0] emiss;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      for (int g = 0; g < 4; g++) m_cnt[i][g] = 1;
      m_tag[i] = 24'd0;
      m_tgt[i] = 32'd0;
    end
    m_ghr = 0; m_total = 32'd0; m_hit = 32'd0; m_miss = 32'd0;
    m_valid = 1'b0; m_taken = 1'b0; m_target = 32'd0; m_pghr = 2'd0;
  endtask

  // Drive one cycle of stimulus, advance the model, sample #1 after the edge.
  task automatic cycle(input logic lv, input logic [31:0] lpc, input logic lbr,
                       input logic uv, input logic [31:0] upc, input logic [1:0] ug,
                       input logic ut, input logic [31:0] utgt, input logic um);
    int ix;
    int ux;
    lk_valid = lv; lk_pc = lpc; lk_is_branch = lbr;
    up_valid = uv; up_pc = upc; up_ghr = ug; up_taken = ut; up_target = utgt; up_mispred = um;
    m_valid = lv;
    if (lv) begin
      ix = int'(lpc[7:0]);
      m_taken  = lbr && (m_cnt[ix][m_ghr] >= 2) && (m_tag[ix] == lpc[31:8]);
      m_target = m_taken ? m_tgt[ix] : lpc + 32'd1;
      m_pghr   = 2'(m_ghr);
    end
    if (uv) begin
      ux = int'(upc[7:0]);
      if (ut) begin
        m_cnt[ux][ug] = (m_cnt[ux][ug] == 3) ? 3 : m_cnt[ux][ug] + 1;
        m_tag[ux] = upc[31:8];
        m_tgt[ux] = utgt;
      end else begin
        m_cnt[ux][ug] = (m_cnt[ux][ug] == 0) ? 0 : m_cnt[ux][ug] - 1;
      end
      m_ghr = (m_ghr * 2 + int'(ut)) % 4;
      m_total++;
      if (um) m_miss++; else m_hit++;
    end
    @(posedge clk); #1;
    lk_valid = 1'b0; up_valid = 1'b0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_valid"},  32'(pr_valid), 32'(m_valid));
    chk({tag, "_taken"},  32'(pr_taken), 32'(m_taken));
    chk({tag, "_target"}, pr_target, m_target);
    chk({tag, "_ghr"},    32'(pr_ghr), 32'(m_pghr));
    chk({tag, "_total"},  st_total, m_total);
    chk({tag, "_hit"},    st_hit, m_hit);
    chk({tag, "_miss"},   st_miss, m_miss);
  endtask

  function automatic logic [31:0] rnd_pc();
    int s;
    s = $urandom_range(0, 3);
    if (s == 3) rnd_pc = $urandom;
    else        rnd_pc = (32'(s) << 8) | (32'($urandom_range(0, 7)) << 2);
  endfunction

  initial begin
    int n;
    int bad;
    rstn = 1'b1; lk_valid = 1'b0; lk_pc = 32'd0; lk_is_branch = 1'b0;
    up_valid = 1'b0; up_pc = 32'd0; up_ghr = 2'd0; up_taken = 1'b0;
    up_target = 32'd0; up_mispred = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_pr_valid", 32'(pr_valid), 32'd0);
    chk("rst_pr_target", pr_target, 32'd0);
    chk("rst_st_total", st_total, 32'd0);
    rstn = 1'b0;
    n = 0;
    while (!ready && n < 400) begin
      @(posedge clk); #1; n++;
    end
    chk("init_len", 32'(n), 32'd256);

    // lv lpc lbr | uv upc ug ut utgt um | ev et etgt eg | tot hit miss
    vq.push_back('{1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h11, 2'd0, 32'd0, 32'd0, 32'd0});
    vq.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 32'h20, 2'd0, 1'b1, 32'h05, 1'b1, 1'b0, 1'b0, 32'h11, 2'd0, 32'd1, 32'd0, 32'd1});
    vq.push_back('{1'b1, 32'h20, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h21, 2'd1, 32'd1, 32'd0, 32'd1});
    vq.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h21, 2'd1, 32'd2, 32'd1, 32'd1});
    vq.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 32'h20, 2'd0, 1'b1, 32'h05, 1'b0, 1'b0, 1'b0, 32'h21, 2'd1, 32'd3, 32'd2, 32'd1});
    vq.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 32'h20, 2'd0, 1'b1, 32'h05, 1'b1, 1'b0, 1'b0, 32'h21, 2'd1, 32'd4, 32'd2, 32'd2});
    vq.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h21, 2'd1, 32'd5, 32'd3, 32'd2});
    vq.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h21, 2'd1, 32'd6, 32'd4, 32'd2});
    vq.push_back('{1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h41, 2'd0, 32'd6, 32'd4, 32'd2});
    vq.push_back('{1'b1, 32'h20, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h05, 2'd0, 32'd6, 32'd4, 32'd2});
    vq.push_back('{1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h21, 2'd0, 32'd6, 32'd4, 32'd2});
    vq.push_back('{1'b1, 32'h120, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h121, 2'd0, 32'd6, 32'd4, 32'd2});
    vq.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 32'h50, 2'd0, 1'b1, 32'h99, 1'b1, 1'b0, 1'b0, 32'h121, 2'd0, 32'd7, 32'd4, 32'd3});
    vq.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 32'h50, 2'd1, 1'b1, 32'h99, 1'b0, 1'b0, 1'b0, 32'h121, 2'd0, 32'd8, 32'd5, 32'd3});
    vq.push_back('{1'b1, 32'h20, 1'b1, 1'b1, 32'h20, 2'd3, 1'b1, 32'h05, 1'b1, 1'b1, 1'b0, 32'h21, 2'd3, 32'd9, 32'd5, 32'd4});
    vq.push_back('{1'b1, 32'h20, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h05, 2'd3, 32'd9, 32'd5, 32'd4});
    vq.push_back('{1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 2'd3, 32'd9, 32'd5, 32'd4});

    foreach (vq[i]) begin
      cycle(vq[i].lv, vq[i].lpc, vq[i].lbr, vq[i].uv, vq[i].upc, vq[i].ug,
            vq[i].ut, vq[i].utgt, vq[i].um);
      chk($sformatf("v%0d_valid", i),  32'(pr_valid), 32'(vq[i].ev));
      chk($sformatf("v%0d_taken", i),  32'(pr_taken), 32'(vq[i].et));
      chk($sformatf("v%0d_target", i), pr_target, vq[i].etgt);
      chk($sformatf("v%0d_ghr", i),    32'(pr_ghr), 32'(vq[i].eg));
      chk($sformatf("v%0d_total", i),  st_total, vq[i].etot);
      chk($sformatf("v%0d_hit", i),    st_hit, vq[i].ehit);
      chk($sformatf("v%0d_miss", i),   st_miss, vq[i].emiss);
    end

    // Reset right after a taken lookup: response dropped, stats cleared, tables re-walked.
    cycle(1'b1, 32'h20, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
    chk("pre_rst_taken", 32'(pr_taken), 32'd1);
    chk("pre_rst_target", pr_target, 32'h05);
    rstn = 1'b1; lk_valid = 1'b1; lk_pc = 32'h20; lk_is_branch = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_pr_valid", 32'(pr_valid), 32'd0);
    chk("mid_rst_pr_taken", 32'(pr_taken), 32'd0);
    chk("mid_rst_st_total", st_total, 32'd0);
    chk("mid_rst_st_miss", st_miss, 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd0);
    rstn = 1'b0;
    up_valid = 1'b1; up_pc = 32'h20; up_ghr = 2'd0; up_taken = 1'b1;
    up_target = 32'h33; up_mispred = 1'b1;
    n = 0; bad = 0;
    while (!ready && n < 400) begin
      @(posedge clk); #1; n++;
      if (pr_valid !== 1'b0 || st_total !== 32'd0) bad++;
    end
    lk_valid = 1'b0; up_valid = 1'b0;
    chk("init_len2", 32'(n), 32'd256);
    chk("init_ignores_io", 32'(bad), 32'd0);
    model_reset();
    cycle(1'b1, 32'h20, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
    chk("reinit_20_taken", 32'(pr_taken), 32'd0);
    chk("reinit_20_target", pr_target, 32'h21);
    cycle(1'b1, 32'h50, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
    chk("reinit_50_taken", 32'(pr_taken), 32'd0);
    chk("reinit_50_target", pr_target, 32'h51);

    // Randomized traffic against the model, biased toward taken to train entries.
    for (int k = 0; k < 1500; k++) begin
      logic lv, lbr, uv, ut, um;
      logic [31:0] lpc, upc, utgt;
      logic [1:0] ug;
      lv   = 1'($urandom_range(0, 1));
      lbr  = ($urandom_range(0, 4) != 0);
      lpc  = rnd_pc();
      uv   = 1'($urandom_range(0, 1));
      upc  = rnd_pc();
      ut   = ($urandom_range(0, 9) < 7);
      utgt = $urandom;
      um   = 1'($urandom_range(0, 1));
      ug   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'(m_ghr);
      cycle(lv, lpc, lbr, uv, upc, ug, ut, utgt, um);
      chk_model("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
